// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: widths, FSM state encoding and
// the latched request record.
package dmem_arbiter_pkg;

  localparam int AW = 5;   // memory word-address width
  localparam int DW = 32;  // data width

  // Arbiter FSM states; encodings are fixed so debug views stay stable.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  // One request as presented by a port and held for the access.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory-side signals of the
// data-memory arbiter. "slave" is the arbiter's view, "master" is the view
// of the surrounding logic (requesters plus memory).
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic          m0_req_i;
  logic          m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_wdata_i;
  logic          m0_gnt_o;
  logic          m0_ack_o;
  logic [DW-1:0] m0_rdata_o;

  logic          m1_req_i;
  logic          m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i;
  logic          m1_gnt_o;
  logic          m1_ack_o;
  logic [DW-1:0] m1_rdata_o;

  logic [AW-1:0] mem_addr_o;
  logic          mem_read_en_o;
  logic          mem_write_en_o;
  logic [DW-1:0] mem_wr_data_o;
  logic [DW-1:0] mem_read_data_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  mem_read_data_i,
    output m0_gnt_o, m0_ack_o, m0_rdata_o,
    output m1_gnt_o, m1_ack_o, m1_rdata_o,
    output mem_addr_o, mem_read_en_o, mem_write_en_o, mem_wr_data_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output mem_read_data_i,
    input  m0_gnt_o, m0_ack_o, m0_rdata_o,
    input  m1_gnt_o, m1_ack_o, m1_rdata_o,
    input  mem_addr_o, mem_read_en_o, mem_write_en_o, mem_wr_data_o
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN -> round-robin on ties (port not granted last
// wins); otherwise fixed priority with port 0 always winning.
module dmem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic winner,
  output logic valid
);

`ifdef DMEM_ARB_RR_EN
  // Round-robin: on a tie the port that did not win last time goes next.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_winner;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end
`else
  // Fixed priority ignores history; keep the input visibly consumed.
  logic unused_last_s;
  assign unused_last_s = last_winner;

  // Fixed priority: port 1 only wins when port 0 is not asking.
  always_comb begin
    valid = req0 | req1;
    if (req0) begin
      winner = 1'b0;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory. Port 0 is the
// LSU, port 1 the debug/loader. Each access runs IDLE -> ACCESS -> DONE, so
// one access completes every three cycles. All outputs are registered.
// Build option: DMEM_ARB_RR_EN selects round-robin instead of fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,   // asynchronous, active low
  dmem_arbiter_if.slave  bus
);

  arb_state_e    state_r, state_nx_s;
  arb_req_t      lat_r, lat_nx_s;
  arb_req_t      port0_s, port1_s;
  logic          owner_r, owner_nx_s;
  logic [1:0]    gnt_r, gnt_nx_s;
  logic [1:0]    ack_r, ack_nx_s;
  logic          mem_re_r, mem_re_nx_s;
  logic          mem_we_r, mem_we_nx_s;
  logic [AW-1:0] mem_addr_r, mem_addr_nx_s;
  logic [DW-1:0] mem_wd_r, mem_wd_nx_s;
  logic [DW-1:0] rdata0_r, rdata0_nx_s;
  logic [DW-1:0] rdata1_r, rdata1_nx_s;
  logic          last_winner_s;
  logic          pick_winner_s;
  logic          pick_valid_s;

  assign port0_s = {bus.m0_we_i, bus.m0_addr_i, bus.m0_wdata_i};
  assign port1_s = {bus.m1_we_i, bus.m1_addr_i, bus.m1_wdata_i};

  dmem_arb_pick u_pick (
    .req0        (bus.m0_req_i),
    .req1        (bus.m1_req_i),
    .last_winner (last_winner_s),
    .winner      (pick_winner_s),
    .valid       (pick_valid_s)
  );

`ifdef DMEM_ARB_RR_EN
  logic last_winner_r;

  // Remember who was granted last; reset value makes port 0 win the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_winner_r <= 1'b1;
    end else if (state_r == ST_IDLE && pick_valid_s) begin
      last_winner_r <= pick_winner_s;
    end
  end

  assign last_winner_s = last_winner_r;
`else
  assign last_winner_s = 1'b0;
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_nx_s    = state_r;
    lat_nx_s      = lat_r;
    owner_nx_s    = owner_r;
    gnt_nx_s      = 2'b00;
    ack_nx_s      = 2'b00;
    mem_re_nx_s   = 1'b0;
    mem_we_nx_s   = 1'b0;
    mem_addr_nx_s = {AW{1'b0}};
    mem_wd_nx_s   = {DW{1'b0}};
    rdata0_nx_s   = rdata0_r;
    rdata1_nx_s   = rdata1_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          if (pick_winner_s) begin
            lat_nx_s = port1_s;
            gnt_nx_s = 2'b10;
          end else begin
            lat_nx_s = port0_s;
            gnt_nx_s = 2'b01;
          end
          owner_nx_s    = pick_winner_s;
          mem_re_nx_s   = ~lat_nx_s.we;
          mem_we_nx_s   = lat_nx_s.we;
          mem_addr_nx_s = lat_nx_s.addr;
          mem_wd_nx_s   = lat_nx_s.wdata;
          state_nx_s    = ST_ACCESS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Memory drove read data at the negedge; it is taken at this edge.
        if (owner_r) begin
          gnt_nx_s = 2'b10;
          ack_nx_s = 2'b10;
        end else begin
          gnt_nx_s = 2'b01;
          ack_nx_s = 2'b01;
        end
        if (!lat_r.we) begin
          if (owner_r) begin
            rdata1_nx_s = bus.mem_read_data_i;
          end else begin
            rdata0_nx_s = bus.mem_read_data_i;
          end
        end else begin
          rdata0_nx_s = rdata0_r;
          rdata1_nx_s = rdata1_r;
        end
        state_nx_s = ST_DONE;
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, latched request and output registers; reset clears everything.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      lat_r      <= '0;
      owner_r    <= 1'b0;
      gnt_r      <= 2'b00;
      ack_r      <= 2'b00;
      mem_re_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= {AW{1'b0}};
      mem_wd_r   <= {DW{1'b0}};
      rdata0_r   <= {DW{1'b0}};
      rdata1_r   <= {DW{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      lat_r      <= lat_nx_s;
      owner_r    <= owner_nx_s;
      gnt_r      <= gnt_nx_s;
      ack_r      <= ack_nx_s;
      mem_re_r   <= mem_re_nx_s;
      mem_we_r   <= mem_we_nx_s;
      mem_addr_r <= mem_addr_nx_s;
      mem_wd_r   <= mem_wd_nx_s;
      rdata0_r   <= rdata0_nx_s;
      rdata1_r   <= rdata1_nx_s;
    end
  end

  assign bus.m0_gnt_o       = gnt_r[0];
  assign bus.m1_gnt_o       = gnt_r[1];
  assign bus.m0_ack_o       = ack_r[0];
  assign bus.m1_ack_o       = ack_r[1];
  assign bus.m0_rdata_o     = rdata0_r;
  assign bus.m1_rdata_o     = rdata1_r;
  assign bus.mem_addr_o     = mem_addr_r;
  assign bus.mem_read_en_o  = mem_re_r;
  assign bus.mem_write_en_o = mem_we_r;
  assign bus.mem_wr_data_o  = mem_wd_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a negedge-sampling memory model
// and a scoreboard of expected completions.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct {
    logic          port;
    logic          rd;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  logic exp_last;
  exp_t sb[$];

  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] mem_rd;

  dmem_arbiter_if bus();

  dmem_arbiter dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: samples enables at the negedge, clears output when not read.
  always @(negedge clk) begin
    if (bus.mem_write_en_o) mem[bus.mem_addr_o] = bus.mem_wr_data_o;
    if (bus.mem_read_en_o) mem_rd = mem[bus.mem_addr_o];
    else mem_rd = 32'd0;
  end
  assign bus.mem_read_data_i = mem_rd;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = a; bus.m0_wdata_i = d;
    end else begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = a; bus.m1_wdata_i = d;
    end
  endtask

  task automatic push_exp(input int p, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    if (we) exp_mem[a] = d;
    e.port  = (p != 0);
    e.rd    = ~we;
    e.rdata = exp_mem[a];
    sb.push_back(e);
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_ack_o, bus.m1_ack_o,
         bus.mem_read_en_o, bus.mem_write_en_o} !== 6'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000", {bus.m0_gnt_o, bus.m1_gnt_o,
               bus.m0_ack_o, bus.m1_ack_o, bus.mem_read_en_o, bus.mem_write_en_o});
    end
    checks++;
    if ({bus.mem_addr_o, bus.mem_wr_data_o, bus.m0_rdata_o, bus.m1_rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h rd0 %h rd1 %h required all 0",
               bus.mem_addr_o, bus.mem_wr_data_o, bus.m0_rdata_o, bus.m1_rdata_o);
    end
  endtask

  task automatic test_single_read();
    int start;
    int got;
    exp_t e;
    push_exp(0, 1'b0, 5'd1, 32'd0);
    drive(0, 1'b1, 1'b0, 5'd1, 32'd0);
    start = cyc;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      checks++;
      if (bus.m1_ack_o !== 1'b0 || bus.m1_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL read_nonowner: m1 gnt %b ack %b required 0", bus.m1_gnt_o, bus.m1_ack_o);
      end
      if (bus.m0_ack_o === 1'b1) begin
        got = 1;
        drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        checks++;
        if (bus.m0_rdata_o !== e.rdata) begin
          errors++;
          $display("FAIL read_data: got %h required %h", bus.m0_rdata_o, e.rdata);
        end
        checks++;
        if (cyc - start != 2) begin
          errors++;
          $display("FAIL read_latency: got %0d required 2", cyc - start);
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL read_timeout: got no ack required ack"); end
    exp_last = 1'b0;
  endtask

  task automatic test_write_read();
    int wcnt;
    int got;
    exp_t e;
    push_exp(1, 1'b1, 5'd7, 32'hDEADBEEF);
    drive(1, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
    wcnt = 0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (bus.mem_write_en_o === 1'b1) begin
        wcnt++;
        checks++;
        if (bus.mem_addr_o !== 5'd7 || bus.mem_wr_data_o !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL write_bus: addr %h data %h required 07 deadbeef",
                   bus.mem_addr_o, bus.mem_wr_data_o);
        end
      end
      if (bus.m1_ack_o === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        drive(1, 1'b0, 1'b0, 5'd0, 32'd0);
      end
    end
    tick();
    checks++;
    if (wcnt != 1 || got == 0) begin
      errors++;
      $display("FAIL write_pulse: write_en cycles %0d ack %0d required 1 1", wcnt, got);
    end
    push_exp(0, 1'b0, 5'd7, 32'd0);
    drive(0, 1'b1, 1'b0, 5'd7, 32'd0);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (bus.m0_ack_o === 1'b1) begin
        got = 1;
        drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        checks++;
        if (bus.m0_rdata_o !== e.rdata) begin
          errors++;
          $display("FAIL readback: got %h required %h", bus.m0_rdata_o, e.rdata);
        end
      end
    end
    checks++;
    if (got == 0 || bus.m1_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL readback_other: ack %0d m1_rdata %h required 1 00000000", got, bus.m1_rdata_o);
    end
    exp_last = 1'b0;
  endtask

  task automatic test_contention();
    int c0;
    int c1;
    int n0;
    int n1;
    int acks;
    logic p;
    logic ap;
    exp_t e;
    p = exp_last;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 8; k++) begin
`ifdef DMEM_ARB_RR_EN
      p = ~p;
`else
      p = (k < 4) ? 1'b0 : 1'b1;
`endif
      if (p) begin push_exp(1, 1'b0, AW'(20 + c1), 32'd0); c1++; end
      else begin push_exp(0, 1'b0, AW'(10 + c0), 32'd0); c0++; end
    end
    exp_last = p;
    drive(0, 1'b1, 1'b0, 5'd10, 32'd0);
    drive(1, 1'b1, 1'b0, 5'd20, 32'd0);
    n0 = 0;
    n1 = 0;
    acks = 0;
    for (int i = 0; i < 60 && acks < 8; i++) begin
      tick();
      checks++;
      if ((bus.m0_gnt_o & bus.m1_gnt_o) !== 1'b0 || (bus.m0_ack_o & bus.m1_ack_o) !== 1'b0) begin
        errors++;
        $display("FAIL excl: gnt %b%b ack %b%b required one-hot or zero",
                 bus.m1_gnt_o, bus.m0_gnt_o, bus.m1_ack_o, bus.m0_ack_o);
      end
      if (bus.m0_ack_o === 1'b1 || bus.m1_ack_o === 1'b1) begin
        ap = bus.m1_ack_o;
        acks++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL order_empty: got ack on port %0d required none", ap);
        end else begin
          e = sb.pop_front();
          if (ap !== e.port || (ap ? bus.m1_rdata_o : bus.m0_rdata_o) !== e.rdata) begin
            errors++;
            $display("FAIL order: ack %0d port %0d data %h required port %0d data %h", acks, ap,
                     ap ? bus.m1_rdata_o : bus.m0_rdata_o, e.port, e.rdata);
          end
        end
        if (ap) begin
          n1++;
          if (n1 < 4) drive(1, 1'b1, 1'b0, AW'(20 + n1), 32'd0);
          else drive(1, 1'b0, 1'b0, 5'd0, 32'd0);
        end else begin
          n0++;
          if (n0 < 4) drive(0, 1'b1, 1'b0, AW'(10 + n0), 32'd0);
          else drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
        end
      end
    end
    checks++;
    if (acks != 8) begin errors++; $display("FAIL contention_count: got %0d acks required 8", acks); end
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
  endtask

  task automatic test_drop();
    int nacc;
    int nack;
    int dropped;
    exp_t e;
    push_exp(1, 1'b0, 5'd5, 32'd0);
    drive(1, 1'b1, 1'b0, 5'd5, 32'd0);
    nacc = 0;
    nack = 0;
    dropped = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_read_en_o === 1'b1 || bus.mem_write_en_o === 1'b1) nacc++;
      if (dropped == 0 && bus.m1_gnt_o === 1'b1) begin
        drive(1, 1'b0, 1'b0, 5'd0, 32'd0);
        dropped = 1;
      end
      if (bus.m1_ack_o === 1'b1) begin
        nack++;
        e = sb.pop_front();
        checks++;
        if (bus.m1_rdata_o !== e.rdata) begin
          errors++;
          $display("FAIL drop_data: got %h required %h", bus.m1_rdata_o, e.rdata);
        end
      end
    end
    checks++;
    if (nacc != 1 || nack != 1 || dropped != 1) begin
      errors++;
      $display("FAIL drop_count: accesses %0d acks %0d granted %0d required 1 1 1", nacc, nack, dropped);
    end
    exp_last = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int seen;
    int bad;
    int got;
    int start;
    exp_t e;
    drive(0, 1'b1, 1'b1, 5'd3, 32'h55);
    seen = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      tick();
      if (bus.mem_write_en_o === 1'b1) seen = 1;
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL rst_write_start: got no write required write"); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_ack_o, bus.m1_ack_o, bus.mem_read_en_o,
         bus.mem_write_en_o, bus.mem_addr_o, bus.mem_wr_data_o, bus.m0_rdata_o,
         bus.m1_rdata_o} !== '0) begin
      errors++;
      $display("FAIL rst_async: gnt %b%b ack %b%b en %b%b addr %h wd %h rd0 %h rd1 %h required all 0",
               bus.m1_gnt_o, bus.m0_gnt_o, bus.m1_ack_o, bus.m0_ack_o, bus.mem_read_en_o,
               bus.mem_write_en_o, bus.mem_addr_o, bus.mem_wr_data_o, bus.m0_rdata_o, bus.m1_rdata_o);
    end
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
    bad = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({bus.m0_ack_o, bus.m1_ack_o, bus.mem_read_en_o, bus.mem_write_en_o} !== 4'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_no_ack: got %0d active cycles required 0", bad); end
    exp_last = 1'b1;
    push_exp(0, 1'b0, 5'd3, 32'd0);
    drive(0, 1'b1, 1'b0, 5'd3, 32'd0);
    start = cyc;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (bus.m0_ack_o === 1'b1) begin
        got = 1;
        drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        checks++;
        if (bus.m0_rdata_o !== e.rdata || cyc - start != 2) begin
          errors++;
          $display("FAIL rst_recover: data %h latency %0d required %h 2", bus.m0_rdata_o,
                   cyc - start, e.rdata);
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL rst_recover_timeout: got no ack required ack"); end
    exp_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int prev;
    exp_t e;
    push_exp(0, 1'b0, 5'd1, 32'd0);
    push_exp(0, 1'b0, 5'd2, 32'd0);
    push_exp(0, 1'b0, 5'd4, 32'd0);
    drive(0, 1'b1, 1'b0, 5'd1, 32'd0);
    n = 0;
    prev = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick();
      if (bus.m0_ack_o === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (bus.m0_rdata_o !== e.rdata) begin
          errors++;
          $display("FAIL b2b_data: ack %0d got %h required %h", n, bus.m0_rdata_o, e.rdata);
        end
        if (n > 0) begin
          checks++;
          if (cyc - prev != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required 3", cyc - prev);
          end
        end
        prev = cyc;
        n++;
        if (n == 1) drive(0, 1'b1, 1'b0, 5'd2, 32'd0);
        else if (n == 2) drive(0, 1'b1, 1'b0, 5'd4, 32'd0);
        else drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d acks required 3", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    exp_last = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 32'(i * 12);
      exp_mem[i] = 32'(i * 12);
    end
    mem_rd = 32'd0;
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_drop();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
